// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp_if
// Brief    : Read/write/control bundle between the pipeline and register_file_mp.
// Revision : 1.0 - initial release
// ============================================================================
interface register_file_mp_if #(
    parameter int NUM_REGS     = 32,
    parameter int XLEN         = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_RD_PORTS-1:0][ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD_PORTS-1:0][XLEN-1:0]   rdata_o;
    logic [NUM_WR_PORTS-1:0]             we_i;
    logic [NUM_WR_PORTS-1:0][ADDR_W-1:0] wr_addr_i;
    logic [NUM_WR_PORTS-1:0][XLEN-1:0]   wr_data_i;
    logic                                clear_i;
    logic                                ready_o;
    logic                                wr_collision_o;

    modport master (
        output rd_addr_i, we_i, wr_addr_i, wr_data_i, clear_i,
        input  rdata_o, ready_o, wr_collision_o
    );

    modport slave (
        input  rd_addr_i, we_i, wr_addr_i, wr_data_i, clear_i,
        output rdata_o, ready_o, wr_collision_o
    );
endinterface
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp
// Brief    : Multi-port register file with write forwarding and scrub FSM.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_mp #(
    parameter int NUM_REGS     = 32,
    parameter int XLEN         = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1,
    parameter int ZERO_REG0    = 1,
    parameter int ADDR_W       = $clog2(NUM_REGS)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    register_file_mp_if.slave  bus
);
    localparam bit              c_zero_reg0 = (ZERO_REG0 != 0);
    localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        SCRUB = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                               r_state;
    state_t                               w_state_next;
    logic [ADDR_W-1:0]                    r_ptr;
    logic [ADDR_W-1:0]                    w_ptr_next;
    logic [XLEN-1:0]                      r_mem [NUM_REGS];
    logic [NUM_WR_PORTS-1:0]              w_wr_eff;
    logic                                 w_collision;
    logic                                 r_collision;
    logic [NUM_RD_PORTS-1:0][XLEN-1:0]    w_rd_next;
    logic [NUM_RD_PORTS-1:0][XLEN-1:0]    r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SCRUB;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            SCRUB: begin
                if (r_ptr == c_last_ptr) begin
                    w_state_next = READY;
                    w_ptr_next   = '0;
                end else begin
                    w_ptr_next = r_ptr + ADDR_W'(1);
                end
            end
            READY: begin
                if (bus.clear_i) begin
                    w_state_next = SCRUB;
                    w_ptr_next   = '0;
                end
            end
            default: begin
                w_state_next = SCRUB;
                w_ptr_next   = '0;
            end
        endcase
    end

    // Writes to a hardwired-zero register are dropped here, so they neither land nor collide.
    always_comb begin
        w_wr_eff = '0;
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            w_wr_eff[w] = bus.we_i[w] && (r_state == READY) &&
                          !(c_zero_reg0 && (bus.wr_addr_i[w] == '0));
        end
    end

    always_comb begin
        w_collision = 1'b0;
        for (int i = 0; i < NUM_WR_PORTS; i++) begin
            for (int j = i + 1; j < NUM_WR_PORTS; j++) begin
                if (w_wr_eff[i] && w_wr_eff[j] && (bus.wr_addr_i[i] == bus.wr_addr_i[j])) begin
                    w_collision = 1'b1;
                end
            end
        end
    end

    // Ascending port order: the last assignment (highest port) wins.
    always_ff @(posedge clk) begin
        if (r_state == SCRUB) begin
            r_mem[r_ptr] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (w_wr_eff[w]) begin
                    r_mem[bus.wr_addr_i[w]] <= bus.wr_data_i[w];
                end
            end
        end
    end

    always_comb begin
        w_rd_next = '0;
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            w_rd_next[r] = r_mem[bus.rd_addr_i[r]];
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (w_wr_eff[w] && (bus.wr_addr_i[w] == bus.rd_addr_i[r])) begin
                    w_rd_next[r] = bus.wr_data_i[w];
                end
            end
            if ((r_state == SCRUB) || (c_zero_reg0 && (bus.rd_addr_i[r] == '0))) begin
                w_rd_next[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata     <= '0;
            r_collision <= 1'b0;
        end else begin
            r_rdata     <= w_rd_next;
            r_collision <= w_collision;
        end
    end

    assign bus.rdata_o        = r_rdata;
    assign bus.ready_o        = (r_state == READY);
    assign bus.wr_collision_o = r_collision;
endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_mp
// Brief    : Self-checking bench for register_file_mp against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_register_file_mp;
    localparam int NUM_REGS = 32;
    localparam int XLEN     = 32;
    localparam int NRD      = 2;
    localparam int NWR      = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    register_file_mp_if #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR)) bus_a ();
    register_file_mp_if #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR)) bus_b ();

    register_file_mp #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .NUM_RD_PORTS(NRD),
                       .NUM_WR_PORTS(NWR), .ZERO_REG0(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    register_file_mp #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .NUM_RD_PORTS(NRD),
                       .NUM_WR_PORTS(NWR), .ZERO_REG0(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: register contents plus the number of scrub cycles still owed.
    logic [XLEN-1:0] model_mem [NUM_REGS];
    int              busy;
    logic [XLEN-1:0] exp_rdata [NRD];
    logic            exp_col;
    logic            exp_ready;

    task automatic idle();
        bus_a.we_i = '0; bus_a.wr_addr_i = '0; bus_a.wr_data_i = '0;
        bus_a.rd_addr_i = '0; bus_a.clear_i = 1'b0;
        bus_b.we_i = '0; bus_b.wr_addr_i = '0; bus_b.wr_data_i = '0;
        bus_b.rd_addr_i = '0; bus_b.clear_i = 1'b0;
    endtask

    task automatic model_wipe();
        for (int i = 0; i < NUM_REGS; i++) model_mem[i] = '0;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        busy = NUM_REGS;
        model_wipe();
    endtask

    // Predict what the next edge produces, update the model, then advance past the edge.
    task automatic step();
        bit rdy;
        bit eff [NWR];
        logic [XLEN-1:0] v;
        rdy = (busy == 0);
        for (int w = 0; w < NWR; w++)
            eff[w] = rdy && bus_a.we_i[w] && (bus_a.wr_addr_i[w] != 0);
        for (int r = 0; r < NRD; r++) begin
            v = model_mem[bus_a.rd_addr_i[r]];
            for (int w = 0; w < NWR; w++)
                if (eff[w] && bus_a.wr_addr_i[w] == bus_a.rd_addr_i[r]) v = bus_a.wr_data_i[w];
            if (!rdy || bus_a.rd_addr_i[r] == 0) v = '0;
            exp_rdata[r] = v;
        end
        exp_col = eff[0] && eff[1] && (bus_a.wr_addr_i[0] == bus_a.wr_addr_i[1]);
        for (int w = 0; w < NWR; w++)
            if (eff[w]) model_mem[bus_a.wr_addr_i[w]] = bus_a.wr_data_i[w];
        if (busy > 0) busy--;
        else if (bus_a.clear_i) begin
            busy = NUM_REGS;
            model_wipe();
        end
        exp_ready = (busy == 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        #2 rst = 1'b1;
        #1;
        for (int r = 0; r < NRD; r++) begin
            n_cmp++;
            if (bus_a.rdata_o[r] !== '0) begin
                n_bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", r, bus_a.rdata_o[r]);
            end
        end
        n_cmp++;
        if (bus_a.ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus_a.ready_o); end
        n_cmp++;
        if (bus_a.wr_collision_o !== 1'b0) begin n_bad++; $display("FAIL reset_col: got %b want 0", bus_a.wr_collision_o); end
        release_reset();
    endtask

    task automatic test_scrub_after_reset();
        for (int i = 1; i <= NUM_REGS; i++) begin
            step();
            n_cmp++;
            if (bus_a.ready_o !== (i == NUM_REGS)) begin
                n_bad++; $display("FAIL scrub_ready edge %0d: got %b want %b", i, bus_a.ready_o, (i == NUM_REGS));
            end
        end
        for (int k = 0; k < NUM_REGS / 2; k++) begin
            bus_a.rd_addr_i[0] = 5'(2 * k);
            bus_a.rd_addr_i[1] = 5'(2 * k + 1);
            step();
            for (int r = 0; r < NRD; r++) begin
                n_cmp++;
                if (bus_a.rdata_o[r] !== 32'h0) begin
                    n_bad++; $display("FAIL scrub_zero reg %0d: got %h want 0", 2 * k + r, bus_a.rdata_o[r]);
                end
            end
        end
    endtask

    task automatic test_forwarding();
        idle();
        bus_a.we_i[0] = 1'b1; bus_a.wr_addr_i[0] = 5'd5; bus_a.wr_data_i[0] = 32'hDEADBEEF;
        bus_a.rd_addr_i[1] = 5'd5;
        step();
        n_cmp++;
        if (bus_a.rdata_o[1] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL fwd_same_cycle: got %h want deadbeef", bus_a.rdata_o[1]);
        end
        idle();
        bus_a.rd_addr_i[1] = 5'd5;
        step();
        n_cmp++;
        if (bus_a.rdata_o[1] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL fwd_next_cycle: got %h want deadbeef", bus_a.rdata_o[1]);
        end
    endtask

    task automatic test_collision();
        idle();
        bus_a.we_i = 2'b11;
        bus_a.wr_addr_i[0] = 5'd7; bus_a.wr_data_i[0] = 32'h11;
        bus_a.wr_addr_i[1] = 5'd7; bus_a.wr_data_i[1] = 32'h22;
        bus_a.rd_addr_i[0] = 5'd7;
        step();
        n_cmp++;
        if (bus_a.wr_collision_o !== 1'b1) begin n_bad++; $display("FAIL col_pulse: got %b want 1", bus_a.wr_collision_o); end
        n_cmp++;
        if (bus_a.rdata_o[0] !== 32'h22) begin n_bad++; $display("FAIL col_fwd_winner: got %h want 22", bus_a.rdata_o[0]); end
        idle();
        bus_a.rd_addr_i[0] = 5'd7;
        step();
        n_cmp++;
        if (bus_a.wr_collision_o !== 1'b0) begin n_bad++; $display("FAIL col_single_cycle: got %b want 0", bus_a.wr_collision_o); end
        n_cmp++;
        if (bus_a.rdata_o[0] !== 32'h22) begin n_bad++; $display("FAIL col_winner: got %h want 22", bus_a.rdata_o[0]); end
    endtask

    task automatic test_zero_reg();
        idle();
        bus_a.we_i = 2'b11;
        bus_a.wr_data_i[0] = 32'h5A; bus_a.wr_data_i[1] = 32'h5A;
        bus_b.we_i[0] = 1'b1; bus_b.wr_data_i[0] = 32'h5A;
        step();
        n_cmp++;
        if (bus_a.wr_collision_o !== 1'b0) begin n_bad++; $display("FAIL zero_no_col: got %b want 0", bus_a.wr_collision_o); end
        n_cmp++;
        if (bus_a.rdata_o[0] !== 32'h0) begin n_bad++; $display("FAIL zero_hard_fwd: got %h want 0", bus_a.rdata_o[0]); end
        idle();
        step();
        n_cmp++;
        if (bus_a.rdata_o[0] !== 32'h0) begin n_bad++; $display("FAIL zero_hard_read: got %h want 0", bus_a.rdata_o[0]); end
        n_cmp++;
        if (bus_b.rdata_o[0] !== 32'h5A) begin n_bad++; $display("FAIL zero_soft_read: got %h want 5a", bus_b.rdata_o[0]); end
    endtask

    task automatic test_clear();
        idle();
        for (int k = 0; k < NUM_REGS / 2; k++) begin
            bus_a.we_i = 2'b11;
            bus_a.wr_addr_i[0] = 5'(2 * k);     bus_a.wr_data_i[0] = $urandom | 32'h1;
            bus_a.wr_addr_i[1] = 5'(2 * k + 1); bus_a.wr_data_i[1] = $urandom | 32'h1;
            step();
        end
        idle();
        bus_a.clear_i = 1'b1;
        bus_a.we_i[0] = 1'b1; bus_a.wr_addr_i[0] = 5'd3; bus_a.wr_data_i[0] = 32'hA5A5_0003;
        bus_a.rd_addr_i[0] = 5'd3;
        step();
        n_cmp++;
        if (bus_a.rdata_o[0] !== 32'hA5A5_0003) begin n_bad++; $display("FAIL clear_edge_fwd: got %h want a5a50003", bus_a.rdata_o[0]); end
        n_cmp++;
        if (bus_a.ready_o !== 1'b0) begin n_bad++; $display("FAIL clear_ready_drop: got %b want 0", bus_a.ready_o); end
        for (int i = 1; i <= NUM_REGS; i++) begin
            bus_a.clear_i = 1'b0;
            bus_a.we_i = 2'(i < NUM_REGS ? 3 : 0);
            bus_a.wr_addr_i[0] = 5'($urandom); bus_a.wr_data_i[0] = $urandom | 32'h1;
            bus_a.wr_addr_i[1] = 5'($urandom); bus_a.wr_data_i[1] = $urandom | 32'h1;
            step();
            n_cmp++;
            if (bus_a.ready_o !== (i == NUM_REGS)) begin
                n_bad++; $display("FAIL clear_ready edge %0d: got %b want %b", i, bus_a.ready_o, (i == NUM_REGS));
            end
        end
        idle();
        for (int k = 0; k < NUM_REGS / 2; k++) begin
            bus_a.rd_addr_i[0] = 5'(2 * k);
            bus_a.rd_addr_i[1] = 5'(2 * k + 1);
            step();
            for (int r = 0; r < NRD; r++) begin
                n_cmp++;
                if (bus_a.rdata_o[r] !== exp_rdata[r]) begin
                    n_bad++; $display("FAIL clear_zero reg %0d: got %h want %h", 2 * k + r, bus_a.rdata_o[r], exp_rdata[r]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_scrub();
        idle();
        bus_a.we_i = 2'b11;
        bus_a.wr_addr_i[0] = 5'd4; bus_a.wr_data_i[0] = 32'h1234;
        bus_a.wr_addr_i[1] = 5'd4; bus_a.wr_data_i[1] = 32'h5678;
        bus_a.rd_addr_i[0] = 5'd4;
        step();
        // Outputs are nonzero here, so the async clear below is observable.
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus_a.rdata_o[0] !== 32'h0) begin n_bad++; $display("FAIL async_rdata: got %h want 0", bus_a.rdata_o[0]); end
        n_cmp++;
        if (bus_a.wr_collision_o !== 1'b0) begin n_bad++; $display("FAIL async_col: got %b want 0", bus_a.wr_collision_o); end
        n_cmp++;
        if (bus_a.ready_o !== 1'b0) begin n_bad++; $display("FAIL async_ready: got %b want 0", bus_a.ready_o); end
        idle();
        release_reset();
        repeat (10) step();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus_a.ready_o !== 1'b0) begin n_bad++; $display("FAIL midscrub_ready: got %b want 0", bus_a.ready_o); end
        release_reset();
        for (int i = 1; i <= NUM_REGS; i++) begin
            step();
            n_cmp++;
            if (bus_a.ready_o !== (i == NUM_REGS)) begin
                n_bad++; $display("FAIL midscrub_restart edge %0d: got %b want %b", i, bus_a.ready_o, (i == NUM_REGS));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus_a.we_i = 2'($urandom);
            for (int w = 0; w < NWR; w++) begin
                bus_a.wr_addr_i[w] = 5'($urandom_range(0, 7));
                bus_a.wr_data_i[w] = $urandom;
            end
            for (int r = 0; r < NRD; r++) bus_a.rd_addr_i[r] = 5'($urandom_range(0, 7));
            bus_a.clear_i = ($urandom_range(0, 63) == 0);
            step();
            for (int r = 0; r < NRD; r++) begin
                n_cmp++;
                if (bus_a.rdata_o[r] !== exp_rdata[r]) begin
                    n_bad++; $display("FAIL rand_rdata[%0d] cyc %0d: got %h want %h", r, c, bus_a.rdata_o[r], exp_rdata[r]);
                end
            end
            n_cmp++;
            if (bus_a.wr_collision_o !== exp_col) begin
                n_bad++; $display("FAIL rand_col cyc %0d: got %b want %b", c, bus_a.wr_collision_o, exp_col);
            end
            n_cmp++;
            if (bus_a.ready_o !== exp_ready) begin
                n_bad++; $display("FAIL rand_ready cyc %0d: got %b want %b", c, bus_a.ready_o, exp_ready);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        busy = NUM_REGS;
        model_wipe();
        test_reset();
        test_scrub_after_reset();
        test_forwarding();
        test_collision();
        test_zero_reg();
        test_clear();
        test_reset_mid_scrub();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
